// File: rtl/fulladd_pkg.sv
// Shared widths, FSM state encoding and vector type for the full-adder self-test engine.
package fulladd_pkg;

   localparam int VEC_W = 3;
   localparam int ERR_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   typedef logic [VEC_W-1:0] vec_t;

endpackage

// File: rtl/fulladd_model.sv
// Golden full-adder reference: vector {A,B,CIN} to expected SUM/COUT.
module fulladd_model
   import fulladd_pkg::*;
(
   input  logic [VEC_W-1:0] v_i,
   output logic             exp_sum_o,
   output logic             exp_cout_o
);

   assign exp_sum_o  = ^v_i;
   assign exp_cout_o = (v_i[2] & v_i[1]) | (v_i[2] & v_i[0]) | (v_i[1] & v_i[0]);

endmodule

// File: rtl/fulladd_bist.sv
// Self-test engine for the 1-bit full adder: walks all eight input vectors LOOPS times,
// samples the response after SETTLE_CYC cycles and keeps an error count plus the first failing vector.
module fulladd_bist
   import fulladd_pkg::*;
#(
   parameter int SETTLE_CYC = 1,
   parameter int LOOPS      = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             dut_sum,
   input  logic             dut_cout,
   output logic             dut_a,
   output logic             dut_b,
   output logic             dut_cin,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_cnt,
   output logic [VEC_W-1:0] first_fail_vec,
   output logic             first_fail_valid,
   output logic [1:0]       dbg_state
);

   // Handshake: start is a level sampled on the rising edge and only honoured in IDLE;
   // abort is sampled every edge and wins over start and over the compare on that edge.

   state_t             state_q;
   vec_t               v_q;
   logic [3:0]         settle_q;
   logic [3:0]         loop_q;
   logic [ERR_W-1:0]   err_q;
   logic [VEC_W-1:0]   ff_vec_q;
   logic               ff_valid_q;
   logic               busy_q;
   logic               done_q;
   logic               pass_q;

   logic               exp_sum;
   logic               exp_cout;
   logic               mismatch_d;
   logic [ERR_W-1:0]   err_d;
   logic               last_settle;
   logic               last_loop;

   fulladd_model u_model (
      .v_i        (v_q),
      .exp_sum_o  (exp_sum),
      .exp_cout_o (exp_cout)
   );

   assign last_settle = (settle_q == 4'(SETTLE_CYC - 1));
   assign last_loop   = (loop_q == 4'(LOOPS - 1));

   // A double-bit miss on one vector still counts once; the count sticks at all-ones.
   always_comb begin
      mismatch_d = (dut_sum != exp_sum) || (dut_cout != exp_cout);
      err_d      = err_q;
      if (mismatch_d && (err_q != {ERR_W{1'b1}})) begin
         err_d = err_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         v_q        <= '0;
         settle_q   <= '0;
         loop_q     <= '0;
         err_q      <= '0;
         ff_vec_q   <= '0;
         ff_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start && !abort) begin
                  state_q    <= ST_DRIVE;
                  busy_q     <= 1'b1;
                  v_q        <= '0;
                  settle_q   <= '0;
                  loop_q     <= '0;
                  err_q      <= '0;
                  ff_vec_q   <= '0;
                  ff_valid_q <= 1'b0;
                  pass_q     <= 1'b0;
               end
            end
            ST_DRIVE: begin
               if (abort) begin
                  state_q  <= ST_IDLE;
                  busy_q   <= 1'b0;
                  pass_q   <= 1'b0;
                  v_q      <= '0;
                  settle_q <= '0;
               end else if (last_settle) begin
                  settle_q <= '0;
                  err_q    <= err_d;
                  if (mismatch_d && !ff_valid_q) begin
                     ff_valid_q <= 1'b1;
                     ff_vec_q   <= v_q;
                  end
                  // v wraps to 000 after 111, which also parks the stimulus at zero for IDLE.
                  v_q <= v_q + 1'b1;
                  if (v_q == {VEC_W{1'b1}}) begin
                     if (last_loop) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_d == '0);
                     end else begin
                        loop_q <= loop_q + 1'b1;
                     end
                  end
               end else begin
                  settle_q <= settle_q + 1'b1;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign dut_a            = v_q[2];
   assign dut_b            = v_q[1];
   assign dut_cin          = v_q[0];
   assign busy             = busy_q;
   assign done             = done_q;
   assign pass             = pass_q;
   assign err_cnt          = err_q;
   assign first_fail_vec   = ff_vec_q;
   assign first_fail_valid = ff_valid_q;
   assign dbg_state        = state_q;

endmodule

// File: tb/tb_fulladd_bist.sv
// Bench for fulladd_bist: two engines (SETTLE=1/LOOPS=1 and SETTLE=3/LOOPS=2) each wrapped around
// a behavioural adder with per-vector fault masks; results are predicted from the masks alone.
module tb_fulladd_bist;
   import fulladd_pkg::*;

   localparam int NI = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start_s [NI];
   logic       abort_s [NI];
   logic       sum_s   [NI];
   logic       cout_s  [NI];
   logic       a_s     [NI];
   logic       b_s     [NI];
   logic       cin_s   [NI];
   logic       busy_s  [NI];
   logic       done_s  [NI];
   logic       pass_s  [NI];
   logic       ffv_s   [NI];
   logic [7:0] err_s   [NI];
   logic [2:0] ffvec_s [NI];
   logic [1:0] st_s    [NI];
   logic [7:0] fs      [NI];
   logic [7:0] fc      [NI];

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      logic [1:0] tot;
      logic [2:0] vin;
      assign vin       = {a_s[g], b_s[g], cin_s[g]};
      assign tot       = 2'(a_s[g]) + 2'(b_s[g]) + 2'(cin_s[g]);
      assign sum_s[g]  = tot[0] ^ fs[g][vin];
      assign cout_s[g] = tot[1] ^ fc[g][vin];

      fulladd_bist #(
         .SETTLE_CYC (g == 0 ? 1 : 3),
         .LOOPS      (g == 0 ? 1 : 2)
      ) u_dut (
         .clk              (clk),
         .rst_n            (rst_n),
         .start            (start_s[g]),
         .abort            (abort_s[g]),
         .dut_sum          (sum_s[g]),
         .dut_cout         (cout_s[g]),
         .dut_a            (a_s[g]),
         .dut_b            (b_s[g]),
         .dut_cin          (cin_s[g]),
         .busy             (busy_s[g]),
         .done             (done_s[g]),
         .pass             (pass_s[g]),
         .err_cnt          (err_s[g]),
         .first_fail_vec   (ffvec_s[g]),
         .first_fail_valid (ffv_s[g]),
         .dbg_state        (st_s[g])
      );
   end

   function automatic int settle_of(input int g);
      return (g == 0) ? 1 : 3;
   endfunction

   function automatic int loops_of(input int g);
      return (g == 0) ? 1 : 2;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One complete run on engine g. abort_at > 0 raises abort so it is sampled at edge t+abort_at;
   // restart_k >= 0 raises a stray start sampled at edge t+restart_k+1.
   task automatic run(input int g, input int abort_at, input int restart_k, input string nm);
      int  s, l, total, end_k, err_e, ff_e, done_k, done_n, bad_vec;
      bit  ffv_e, aborted;
      s       = settle_of(g);
      l       = loops_of(g);
      total   = 8 * l * s;
      aborted = (abort_at > 0);

      // Reference: sample j checks vector j%8 at edge t+(j+1)*s; an abort on that edge drops it.
      err_e = 0; ffv_e = 1'b0; ff_e = 0;
      for (int j = 0; j < 8 * l; j++) begin
         int v;
         v = j % 8;
         if (aborted && ((j + 1) * s >= abort_at)) break;
         if (fs[g][v] | fc[g][v]) begin
            if (err_e < 255) err_e++;
            if (!ffv_e) begin
               ffv_e = 1'b1;
               ff_e  = v;
            end
         end
      end

      @(negedge clk);
      start_s[g] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_s[g] = 1'b0;

      end_k   = aborted ? abort_at : total + 1;
      done_k  = -1;
      done_n  = 0;
      bad_vec = 0;
      for (int k = 0; k <= end_k; k++) begin
         if ((k < total) && !(aborted && (k >= abort_at))) begin
            if (({a_s[g], b_s[g], cin_s[g]} !== 3'((k / s) % 8)) || (busy_s[g] !== 1'b1))
               bad_vec++;
         end
         if (done_s[g] === 1'b1) begin
            done_n++;
            done_k = k;
         end
         if (k == abort_at - 1) abort_s[g] = 1'b1;
         if (k == restart_k)    start_s[g] = 1'b1;
         if (k < end_k) begin
            @(posedge clk);
            @(negedge clk);
            abort_s[g] = 1'b0;
            start_s[g] = 1'b0;
         end
      end

      check($sformatf("%s vec_seq_bad_cycles", nm), bad_vec, 0);
      check($sformatf("%s done_pulses", nm), done_n, aborted ? 0 : 1);
      if (!aborted) check($sformatf("%s done_cycle", nm), done_k, total);
      check($sformatf("%s busy_after", nm), busy_s[g], 1'b0);
      check($sformatf("%s stim_idle", nm), {a_s[g], b_s[g], cin_s[g]}, 3'b000);
      check($sformatf("%s err_cnt", nm), err_s[g], err_e);
      check($sformatf("%s pass", nm), pass_s[g], (!aborted && err_e == 0));
      check($sformatf("%s ff_valid", nm), ffv_s[g], ffv_e);
      if (ffv_e) check($sformatf("%s ff_vec", nm), ffvec_s[g], ff_e);
      @(negedge clk);
      @(negedge clk);
      check($sformatf("%s pass_held", nm), pass_s[g], (!aborted && err_e == 0));
      check($sformatf("%s state_idle", nm), st_s[g], ST_IDLE);
   endtask

   initial begin
      int g, tot, ab, rs;
      rst_n = 1'b0;
      for (int i = 0; i < NI; i++) begin
         start_s[i] = 1'b0;
         abort_s[i] = 1'b0;
         fs[i]      = 8'h00;
         fc[i]      = 8'h00;
      end

      // Reset state of both engines
      #12;
      for (int i = 0; i < NI; i++) begin
         check($sformatf("rst%0d busy", i), busy_s[i], 1'b0);
         check($sformatf("rst%0d done", i), done_s[i], 1'b0);
         check($sformatf("rst%0d pass", i), pass_s[i], 1'b0);
         check($sformatf("rst%0d err", i), err_s[i], 0);
         check($sformatf("rst%0d ffv", i), ffv_s[i], 1'b0);
         check($sformatf("rst%0d stim", i), {a_s[i], b_s[i], cin_s[i]}, 3'b000);
         check($sformatf("rst%0d state", i), st_s[i], ST_IDLE);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed: good adder, SUM stuck-at-0, COUT inverted, long settle with stray start
      run(0, -1, -1, "clean_s1");
      for (int v = 0; v < 8; v++) fs[0][v] = ($countones(3'(v)) % 2 == 1);
      run(0, -1, -1, "sum_sa0");
      fc[1] = 8'hFF;
      run(1, -1, -1, "cout_inv_l2");
      fc[1] = 8'h00;
      run(1, -1, 4, "clean_s3_restart");
      run(0, 4, -1, "sum_sa0_abort");
      run(0, -1, 8, "start_in_done");

      // start and abort together in IDLE: abort wins
      @(negedge clk);
      start_s[0] = 1'b1;
      abort_s[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_s[0] = 1'b0;
      abort_s[0] = 1'b0;
      check("start_abort busy", busy_s[0], 1'b0);
      check("start_abort state", st_s[0], ST_IDLE);

      // Randomized fault masks, aborts and stray starts
      for (int r = 0; r < 8; r++) begin
         g     = r % 2;
         tot   = 8 * loops_of(g) * settle_of(g);
         fs[g] = 8'($urandom);
         fc[g] = 8'($urandom) & 8'($urandom);
         if (r == 2) begin
            fs[g] = 8'h00;
            fc[g] = 8'h00;
         end
         ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, tot)) : -1;
         rs = ((ab < 0) && ($urandom_range(0, 1) == 1)) ? int'($urandom_range(0, tot)) : -1;
         run(g, ab, rs, $sformatf("rand%0d", r));
      end

      // Asynchronous reset mid-run, then a clean run
      for (int v = 0; v < 8; v++) fs[0][v] = ($countones(3'(v)) % 2 == 1);
      fc[0] = 8'h00;
      @(negedge clk);
      start_s[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_s[0] = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst busy", busy_s[0], 1'b0);
      check("midrst stim", {a_s[0], b_s[0], cin_s[0]}, 3'b000);
      check("midrst err", err_s[0], 0);
      check("midrst ffv", ffv_s[0], 1'b0);
      check("midrst ffvec", ffvec_s[0], 3'b000);
      check("midrst pass", pass_s[0], 1'b0);
      check("midrst done", done_s[0], 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      fs[0] = 8'h00;
      run(0, -1, -1, "post_reset_clean");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
